// File: rtl/leaf_user_packetizer.sv
// Transmit endpoint of a BFT leaf: buffers user words from an ap_vld/ap_ack
// stream, wraps them into addressed packets and meters them by receiver credits.
module leaf_user_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FIFO_DEPTH            = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_user,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic                     cfg_valid,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
  input  logic                     credit_update,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     dout_ready,
  output logic                     credit_err
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int CREDIT_W = NUM_ADDR_BITS + 1;

  localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(1 << NUM_ADDR_BITS);
  localparam logic [CREDIT_W:0]   CREDIT_INC = (CREDIT_W + 1)'(FREESPACE_UPDATE_SIZE);

  logic [PAYLOAD_BITS-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic                     configured;
  logic [NUM_LEAF_BITS-1:0] dst_leaf;
  logic [NUM_PORT_BITS-1:0] dst_port;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic [CREDIT_W-1:0]      credit;
  logic [CREDIT_W-1:0]      credit_next;
  logic [CREDIT_W:0]        credit_sum;
  logic                     credit_overflow;
  logic                     out_vld;
  logic                     push;
  logic                     load;

  assign out_vld = dout_leaf_interface2bft[PACKET_BITS-1];
  assign push    = vld_user2interface && ack_interface2user;
  assign load    = configured && (count != '0) && (credit != '0) && (!out_vld || dout_ready);

  always_comb begin
    count_next = count;
    case ({push, load})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Credit sum is one bit wider than the counter so an over-return is visible before clamping.
  always_comb begin
    credit_sum      = {1'b0, credit} + (credit_update ? CREDIT_INC : '0) - (CREDIT_W + 1)'(load);
    credit_overflow = credit_sum > {1'b0, CREDIT_MAX};
    credit_next     = credit_overflow ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
  end

  // Storage needs no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_user) begin
    if (push) begin
      fifo_mem[wr_ptr] <= din_leaf_user2interface;
    end
  end

  always_ff @(posedge clk_user) begin
    if (!reset) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      ack_interface2user      <= 1'b0;
      configured              <= 1'b0;
      dst_leaf                <= '0;
      dst_port                <= '0;
      addr                    <= '0;
      credit                  <= CREDIT_MAX;
      credit_err              <= 1'b0;
      dout_leaf_interface2bft <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count              <= count_next;
      ack_interface2user <= (count_next != FIFO_FULL);

      if (cfg_valid) begin
        configured <= 1'b1;
        dst_leaf   <= cfg_dst_leaf;
        dst_port   <= cfg_dst_port;
      end

      credit <= credit_next;
      if (credit_overflow) begin
        credit_err <= 1'b1;
      end

      // The held packet only changes on a load or once the BFT side has taken it.
      if (load) begin
        dout_leaf_interface2bft <= {1'b1, dst_leaf, dst_port, addr, fifo_mem[rd_ptr]};
        addr                    <= addr + NUM_ADDR_BITS'(1);
      end else if (dout_ready && out_vld) begin
        dout_leaf_interface2bft <= '0;
      end
    end
  end

endmodule

// File: tb/tb_leaf_user_packetizer.sv
// Directed self-checking bench for leaf_user_packetizer: handshake timing, burst
// with address wrap, backpressure, credit clamping, reconfiguration and reset.
module tb_leaf_user_packetizer;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic        cfg_valid;
  logic [4:0]  cfg_dst_leaf;
  logic [3:0]  cfg_dst_port;
  logic        credit_update;
  logic [48:0] dout_leaf_interface2bft;
  logic        dout_ready;
  logic        credit_err;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          words_total, sent, rcvd;
  logic [31:0] base_word;
  logic [4:0]  exp_leaf;
  logic [3:0]  exp_port;
  int          first_cyc, last_cyc, p128_cyc, upd_cyc;

  leaf_user_packetizer dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .cfg_valid               (cfg_valid),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .credit_update           (credit_update),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .dout_ready              (dout_ready),
    .credit_err              (credit_err)
  );

  always #5 clk_user = ~clk_user;

  function automatic logic [48:0] mkpkt(input logic [4:0] l, input logic [3:0] p,
                                        input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic step();
    @(posedge clk_user);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input int n);
    reset              = 1'b0;
    vld_user2interface = 1'b0;
    cfg_valid          = 1'b0;
    credit_update      = 1'b0;
    dout_ready         = 1'b0;
    repeat (n) step();
    reset = 1'b1;
    sent  = 0;
    rcvd  = 0;
  endtask

  task automatic configure(input logic [4:0] l, input logic [3:0] p);
    cfg_valid    = 1'b1;
    cfg_dst_leaf = l;
    cfg_dst_port = p;
    step();
    cfg_valid = 1'b0;
  endtask

  // One clock of streaming: score a packet the BFT side takes at the coming edge, offer the next word.
  task automatic applyStimulus();
    logic acc;
    if (dout_leaf_interface2bft[48] && dout_ready) begin
      checkOutput($sformatf("pkt%0d", rcvd), dout_leaf_interface2bft,
                  mkpkt(exp_leaf, exp_port, 7'(rcvd), base_word + 32'(rcvd)));
      if (rcvd == 0)   first_cyc = cyc;
      if (rcvd == 127) last_cyc  = cyc;
      if (rcvd == 128) p128_cyc  = cyc;
      rcvd++;
    end
    vld_user2interface      = (sent < words_total);
    din_leaf_user2interface = base_word + 32'(sent);
    acc = vld_user2interface && ack_interface2user;
    step();
    if (acc) sent++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    din_leaf_user2interface = '0;
    cfg_dst_leaf = '0;
    cfg_dst_port = '0;
    words_total  = 0;
    base_word    = '0;
    exp_leaf     = 5'h03;
    exp_port     = 4'h2;

    // Reset state, ack timing and a single packet.
    doReset(2);
    checkOutput("rst_dout", dout_leaf_interface2bft, 64'h0);
    checkOutput("rst_err", credit_err, 64'h0);
    checkOutput("ack_release_cycle1", ack_interface2user, 64'h0);
    step();
    checkOutput("ack_release_cycle2", ack_interface2user, 64'h1);
    configure(5'h03, 4'h2);
    dout_ready              = 1'b1;
    vld_user2interface      = 1'b1;
    din_leaf_user2interface = 32'hDEADBEEF;
    step();
    vld_user2interface = 1'b0;
    checkOutput("single_lat1", dout_leaf_interface2bft, 64'h0);
    step();
    checkOutput("single_pkt", dout_leaf_interface2bft, mkpkt(5'h03, 4'h2, 7'h00, 32'hDEADBEEF));
    step();
    checkOutput("single_clear", dout_leaf_interface2bft, 64'h0);

    // Backpressure: one packet held, four words queued, sixth word refused.
    doReset(1);
    configure(5'h03, 4'h2);
    words_total = 6;
    base_word   = 32'hA000_0000;
    repeat (6) applyStimulus();
    checkOutput("bp_hold_a", dout_leaf_interface2bft, mkpkt(5'h03, 4'h2, 7'h00, 32'hA000_0000));
    repeat (4) applyStimulus();
    checkOutput("bp_hold_b", dout_leaf_interface2bft, mkpkt(5'h03, 4'h2, 7'h00, 32'hA000_0000));
    checkOutput("bp_accepted", 64'(sent), 64'd5);
    checkOutput("bp_ack_low", ack_interface2user, 64'h0);
    dout_ready = 1'b1;
    for (int i = 0; i < 30 && rcvd < 6; i++) applyStimulus();
    checkOutput("bp_drained", 64'(rcvd), 64'd6);
    checkOutput("bp_all_sent", 64'(sent), 64'd6);

    // Reconfiguration while a packet is held.
    doReset(1);
    configure(5'h03, 4'h2);
    words_total = 2;
    base_word   = 32'hB000_0000;
    repeat (5) applyStimulus();
    configure(5'h1F, 4'h2);
    checkOutput("recfg_held", dout_leaf_interface2bft, mkpkt(5'h03, 4'h2, 7'h00, 32'hB000_0000));
    dout_ready = 1'b1;
    step();
    checkOutput("recfg_next", dout_leaf_interface2bft, mkpkt(5'h1F, 4'h2, 7'h01, 32'hB000_0001));

    // Reset mid-stream with a held packet and three queued words.
    doReset(1);
    configure(5'h03, 4'h2);
    words_total = 4;
    base_word   = 32'hC000_0000;
    repeat (6) applyStimulus();
    checkOutput("mid_queued", 64'(sent), 64'd4);
    checkOutput("mid_held", dout_leaf_interface2bft, mkpkt(5'h03, 4'h2, 7'h00, 32'hC000_0000));
    vld_user2interface = 1'b0;
    reset = 1'b0;
    step();
    checkOutput("mid_rst_dout", dout_leaf_interface2bft, 64'h0);
    checkOutput("mid_rst_ack", ack_interface2user, 64'h0);
    reset      = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("mid_no_stale%0d", i), dout_leaf_interface2bft, 64'h0);
    end
    sent        = 0;
    rcvd        = 0;
    words_total = 1;
    base_word   = 32'hD000_0000;
    repeat (4) applyStimulus();
    checkOutput("unconf_accept", 64'(sent), 64'd1);
    checkOutput("unconf_idle", dout_leaf_interface2bft, 64'h0);
    configure(5'h03, 4'h2);
    repeat (3) applyStimulus();
    checkOutput("reconf_delivered", 64'(rcvd), 64'd1);

    // Overflow at full credit, then a 130-word burst with address wrap.
    doReset(1);
    checkOutput("ovf_err_before", credit_err, 64'h0);
    credit_update = 1'b1;
    step();
    credit_update = 1'b0;
    checkOutput("ovf_err_set", credit_err, 64'h1);
    configure(5'h03, 4'h2);
    dout_ready  = 1'b1;
    words_total = 130;
    base_word   = 32'hE000_0000;
    for (int i = 0; i < 400 && rcvd < 128; i++) applyStimulus();
    checkOutput("burst_128", 64'(rcvd), 64'd128);
    checkOutput("burst_no_stall", 64'(last_cyc - first_cyc), 64'd127);
    repeat (5) applyStimulus();
    checkOutput("burst_credit_stall", 64'(rcvd), 64'd128);
    checkOutput("burst_stall_idle", dout_leaf_interface2bft, 64'h0);
    checkOutput("ovf_err_sticky", credit_err, 64'h1);
    upd_cyc       = cyc;
    credit_update = 1'b1;
    applyStimulus();
    credit_update = 1'b0;
    for (int i = 0; i < 20 && rcvd < 130; i++) applyStimulus();
    checkOutput("burst_130", 64'(rcvd), 64'd130);
    checkOutput("burst_resume_time", 64'(p128_cyc - upd_cyc), 64'd2);

    // Credit update coinciding with the load that spends the last credit.
    doReset(1);
    checkOutput("sim_err_cleared", credit_err, 64'h0);
    configure(5'h03, 4'h2);
    dout_ready  = 1'b1;
    words_total = 127;
    base_word   = 32'hF000_0000;
    for (int i = 0; i < 400 && rcvd < 127; i++) applyStimulus();
    repeat (3) applyStimulus();
    checkOutput("sim_127", 64'(rcvd), 64'd127);
    words_total = 128;
    applyStimulus();
    credit_update = 1'b1;
    applyStimulus();
    credit_update = 1'b0;
    words_total = 220;
    repeat (120) applyStimulus();
    checkOutput("sim_total_192", 64'(rcvd), 64'd192);
    checkOutput("sim_stall_idle", dout_leaf_interface2bft, 64'h0);
    checkOutput("sim_no_err", credit_err, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
